// File: rtl/packet_scheduler_pkg.sv
// Shared types and constants for the monitor-link packet scheduler.
package packet_scheduler_pkg;

  localparam int unsigned PKT_W = 40;
  localparam logic [PKT_W-1:0] AUDIO_REQ_PKT = 40'h0700000000;
  // 41 packet bits + 3 gap bits + 1 turnaround cycle at the sender
  localparam int unsigned HOLDOFF_DEFAULT = 41 + 3 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    AUDIO = 2'd2
  } state_t;

endpackage

// File: rtl/packet_scheduler_pkt_fifo.sv
// Synchronous FIFO for low-priority packets; head is visible on pop_data.
module pkt_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_scheduler.sv
// Paces control and data packets into the serial sender and generates the
// audio-sample-request mode and tick.
module packet_scheduler
  import packet_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned HOLDOFF            = HOLDOFF_DEFAULT,
  parameter int unsigned AUDIO_REQ_INTERVAL = 114
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PKT_W-1:0] ctl_data,
  input  logic             ctl_valid,
  output logic             ctl_ready,
  input  logic [PKT_W-1:0] dat_data,
  input  logic             dat_valid,
  output logic             dat_ready,
  input  logic             audio_enable,
  output logic [PKT_W-1:0] out_data,
  output logic             out_data_valid,
  output logic             audio_sample_request_mode,
  output logic             audio_sample_request_tick,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HW = $clog2(HOLDOFF + 1);
  localparam int unsigned TW = $clog2(AUDIO_REQ_INTERVAL + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(AUDIO_REQ_INTERVAL - 1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [TW-1:0]    tick_cnt;
  logic             run_q;
  logic             ctl_full;
  logic [PKT_W-1:0] ctl_q;

  logic [PKT_W-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             ctl_load;
  logic             ctl_clr;
  logic             pkt_avail;
  logic             issue;
  logic [PKT_W-1:0] issue_pkt;

  // run_q keeps both ready outputs low while reset is asserted.
  assign ctl_ready = run_q & ~ctl_full;
  assign dat_ready = run_q & (fifo_count < CW'(FIFO_DEPTH));

  // Issue decision; the control register always beats the FIFO head.
  always_comb begin
    ctl_load  = ctl_valid & ctl_ready;
    fifo_push = dat_valid & dat_ready & ~fifo_full;
    pkt_avail = ctl_full | ~fifo_empty;
    issue_pkt = ctl_full ? ctl_q : fifo_head;
    issue     = 1'b0;
    case (state)
      IDLE:    issue = ~audio_enable & pkt_avail;
      AUDIO:   issue = audio_sample_request_tick & pkt_avail;
      default: issue = 1'b0;
    endcase
    ctl_clr  = issue & ctl_full;
    fifo_pop = issue & ~ctl_full;
  end

  pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (dat_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      ctl_full <= 1'b0;
      ctl_q    <= '0;
      overflow <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (ctl_load) begin
        ctl_q    <= ctl_data;
        ctl_full <= 1'b1;
      end else if (ctl_clr) begin
        ctl_full <= 1'b0;
      end
      if ((ctl_valid & ~ctl_ready) | (dat_valid & ~dat_ready)) overflow <= 1'b1;
    end
  end

  // Issue pacing FSM; mode only follows audio_enable from IDLE so it never
  // changes while the sender is mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      hold_cnt                  <= '0;
      out_data                  <= '0;
      out_data_valid            <= 1'b0;
      audio_sample_request_mode <= 1'b0;
    end else begin
      out_data_valid <= issue;
      if (issue) out_data <= issue_pkt;
      case (state)
        IDLE: begin
          audio_sample_request_mode <= audio_enable;
          if (audio_enable) begin
            state <= AUDIO;
          end else if (issue) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (hold_cnt <= HW'(1)) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        AUDIO: begin
          if (!issue && !audio_enable) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tick generator: free-runs only while the mode output is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt                  <= '0;
      audio_sample_request_tick <= 1'b0;
    end else if (!audio_sample_request_mode) begin
      tick_cnt                  <= '0;
      audio_sample_request_tick <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt                  <= '0;
      audio_sample_request_tick <= 1'b1;
    end else begin
      tick_cnt                  <= tick_cnt + TW'(1);
      audio_sample_request_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler with a packet scoreboard and timing checks.
module tb_packet_scheduler;
  import packet_scheduler_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PKT_W-1:0] ctl_data;
  logic             ctl_valid;
  logic             ctl_ready;
  logic [PKT_W-1:0] dat_data;
  logic             dat_valid;
  logic             dat_ready;
  logic             audio_enable;
  logic [PKT_W-1:0] out_data;
  logic             out_data_valid;
  logic             mode;
  logic             tick;
  logic             overflow;

  packet_scheduler dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .ctl_data                  (ctl_data),
    .ctl_valid                 (ctl_valid),
    .ctl_ready                 (ctl_ready),
    .dat_data                  (dat_data),
    .dat_valid                 (dat_valid),
    .dat_ready                 (dat_ready),
    .audio_enable              (audio_enable),
    .out_data                  (out_data),
    .out_data_valid            (out_data_valid),
    .audio_sample_request_mode (mode),
    .audio_sample_request_tick (tick),
    .overflow                  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic [PKT_W-1:0] exp_q[$];
  int pulse_cyc[$];
  int tick_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every issue pulse must match the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_data_valid === 1'b1) begin
        pulse_cyc.push_back(cyc);
        check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      if (tick === 1'b1) tick_cyc.push_back(cyc);
    end
  end

  function automatic int pc(input int i);
    return (pulse_cyc.size() > i) ? pulse_cyc[i] : -1;
  endfunction

  function automatic int tc(input int i);
    return (tick_cyc.size() > i) ? tick_cyc[i] : -1;
  endfunction

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n = 0;
    while (pulse_cyc.size() < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(pulse_cyc.size() >= target), 64'd1);
  endtask

  task automatic push_dat(input logic [PKT_W-1:0] d, input bit expect_out);
    if (expect_out) exp_q.push_back(d);
    dat_data  = d;
    dat_valid = 1'b1;
    @(negedge clk);
    dat_valid = 1'b0;
  endtask

  initial begin
    int m;
    int p;
    int nt;
    int n;
    rst_n        = 1'b0;
    ctl_data     = '0;
    ctl_valid    = 1'b0;
    dat_data     = '0;
    dat_valid    = 1'b0;
    audio_enable = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({ctl_ready, dat_ready, out_data_valid, mode, tick, overflow, out_data}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 64'({ctl_ready, dat_ready}), 64'b11);

    // Normal pacing: three back-to-back pushes, issued 45 cycles apart
    exp_q.push_back(40'h0000000091);
    exp_q.push_back(40'h0000000093);
    exp_q.push_back(40'h0000000097);
    dat_valid = 1'b1;
    dat_data  = 40'h0000000091; @(negedge clk);
    dat_data  = 40'h0000000093; @(negedge clk);
    dat_data  = 40'h0000000097; @(negedge clk);
    dat_valid = 1'b0;
    wait_pulses(3, 300, "pacing");
    check("pacing_gap1", 64'(pc(1) - pc(0)), 64'd45);
    check("pacing_gap2", 64'(pc(2) - pc(1)), 64'd45);
    repeat (60) @(negedge clk);

    // Priority: A, B in FIFO; control C arrives during HOLD -> A, C, B
    exp_q.push_back(40'h11_0000_000A);
    exp_q.push_back(40'h33_0000_000C);
    exp_q.push_back(40'h22_0000_000B);
    push_dat(40'h11_0000_000A, 1'b0);
    push_dat(40'h22_0000_000B, 1'b0);
    repeat (4) @(negedge clk);
    check("ctl_ready_hold", 64'(ctl_ready), 64'd1);
    ctl_data  = 40'h33_0000_000C;
    ctl_valid = 1'b1;
    @(negedge clk);
    ctl_valid = 1'b0;
    check("ctl_ready_loaded", 64'(ctl_ready), 64'd0);
    wait_pulses(6, 300, "priority");
    check("prio_gap1", 64'(pc(4) - pc(3)), 64'd45);
    check("prio_gap2", 64'(pc(5) - pc(4)), 64'd45);
    repeat (60) @(negedge clk);

    // Audio mode entry, then overflow while no tick has drained the FIFO
    audio_enable = 1'b1;
    @(negedge clk);
    m = cyc;
    check("mode_rise", 64'(mode), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("dat_ready_fill", 64'(dat_ready), 64'd1);
      push_dat(40'hD0_0000_0000 + 40'(i), i < 4);
    end
    check("dat_ready_full", 64'(dat_ready), 64'd0);
    push_dat(40'hD0_0000_0004, 1'b0);
    check("overflow_set", 64'(overflow), 64'd1);

    // First audio issue follows the first tick
    wait_pulses(7, 300, "audio1");
    check("tick1_time", 64'(tc(0) - m), 64'd114);
    check("audio1_after_tick", 64'(pc(6) - tc(0)), 64'd1);

    // Second audio issue; drop audio_enable on that pulse cycle
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_data_valid !== 1'b1 && n < 300);
    check("audio2_timeout", 64'(out_data_valid), 64'd1);
    audio_enable = 1'b0;
    p  = cyc;
    nt = tick_cyc.size();
    check("tick_period", 64'(tc(1) - tc(0)), 64'd114);
    check("audio2_after_tick", 64'(p - tc(1)), 64'd1);

    // Mode held through the 44-cycle drain, then normal issuing resumes
    while (cyc < p + 45) @(negedge clk);
    check("mode_deferred", 64'(mode), 64'd1);
    @(negedge clk);
    check("mode_fall", 64'(mode), 64'd0);
    wait_pulses(10, 200, "resume");
    check("resume_first", 64'(pc(8) - p), 64'd46);
    check("resume_gap", 64'(pc(9) - pc(8)), 64'd45);
    repeat (150) @(negedge clk);
    check("no_tick_after_mode", 64'(tick_cyc.size()), 64'(nt));
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Reset mid-HOLD with three packets still queued
    push_dat(40'hE0_0000_0000, 1'b1);
    push_dat(40'hE0_0000_0001, 1'b0);
    push_dat(40'hE0_0000_0002, 1'b0);
    push_dat(40'hE0_0000_0003, 1'b0);
    repeat (10) @(negedge clk);
    wait_pulses(11, 20, "pre_reset");
    check("fifo_three_left", 64'(dat_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 64'({ctl_ready, dat_ready, out_data_valid, mode, tick, overflow, out_data}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nt = pulse_cyc.size();
    repeat (200) @(negedge clk);
    check("post_reset_dat_ready", 64'(dat_ready), 64'd1);
    check("post_reset_no_pulse", 64'(pulse_cyc.size()), 64'(nt));
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_scheduler.md
Name: packet_scheduler

Overview:
- Sits directly upstream of the serial packet sender in the NeXT monitor-link path.
- Collects 40-bit outbound packets from two request sources: a high-priority control source and a low-priority data source.
- Issues them as single-cycle in_data_valid pulses, paced so the sender never holds more than one pending packet.
- Generates the periodic audio-sample-request tick and a glitch-free audio mode signal.

Parameters:
- FIFO_DEPTH, 4, entries in the low-priority packet FIFO (power of two, ≥2).
- HOLDOFF, 45, cycles after an issue pulse before the next issue outside audio mode (41 packet bits + 3 gap + 1).
- AUDIO_REQ_INTERVAL, 114, tick period in clk cycles while audio mode is active.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ctl_data  in  40  high-priority packet
- ctl_valid  in  1  ctl_data valid
- ctl_ready  out  1  high = one-entry control register empty
- dat_data  in  40  low-priority packet
- dat_valid  in  1  dat_data valid
- dat_ready  out  1  high = FIFO not full
- audio_enable  in  1  request for audio-sample-request mode
- out_data  out  40  packet to sender
- out_data_valid  out  1  one-cycle issue pulse
- audio_sample_request_mode  out  1  mode to sender
- audio_sample_request_tick  out  1  one-cycle tick to sender
- overflow  out  1  sticky: a push was attempted while not ready

Behaviour:
- Reset (async, rst_n low) clears the following:
  - All outputs to 0; out_data is 0.
  - FIFO pointers and control register cleared.
  - Holdoff and tick counters cleared; state IDLE.
  - A reset mid-packet drops all queued packets.
- Accept rules:
  - The control register loads on ctl_valid & ctl_ready.
  - The FIFO pushes on dat_valid & dat_ready.
  - A push while not ready sets overflow and discards the data.
  - overflow clears only on reset.
- Selection: the control packet always wins over the FIFO head. On a simultaneous push and pop of the FIFO, both occur and the count is unchanged.
- Issue registers: out_data and out_data_valid are registered. The pulse is asserted the cycle after the issue decision. A pop or control-register clear happens in the same cycle as the pulse.
- State machine:
  - IDLE, normal mode, packet available → issue, load holdoff = HOLDOFF-1, go HOLD.
  - HOLD decrements the holdoff each cycle; at 0 → IDLE. Back-to-back packets are therefore spaced exactly HOLDOFF cycles apart.
  - IDLE, audio mode → AUDIO. Packets are not issued freely in AUDIO.
  - AUDIO, on a tick cycle: if a packet is available, issue it on the cycle after the tick (sender buffers it behind the request packet). At most one data packet per tick period. Otherwise no issue.
  - AUDIO, audio_enable low and no issue pending → HOLD with holdoff = HOLDOFF-1. This drains the sender before normal issuing resumes.
- Mode output:
  - audio_sample_request_mode follows audio_enable only when the state is IDLE.
  - While in HOLD, a change of audio_enable is deferred until return to IDLE. The mode never toggles during a sender transfer.
- Tick counter:
  - Runs 0..AUDIO_REQ_INTERVAL-1 only while audio_sample_request_mode = 1; held at 0 otherwise.
  - Tick is asserted for one cycle when the counter equals AUDIO_REQ_INTERVAL-1, then the counter wraps to 0.
  - The first tick comes AUDIO_REQ_INTERVAL cycles after mode rises.
- Ready outputs: ctl_ready = control register empty; dat_ready = FIFO count < FIFO_DEPTH. Both are combinational from registered state only.

Decomposition:
- Shared package contents:
  - PKT_W = 40.
  - Audio request packet constant 40'h0700000000.
  - Default HOLDOFF derived as 41+3+1.
  - State enum {IDLE, HOLD, AUDIO}.
- One natural sub-module: pkt_fifo, a parameterised synchronous FIFO (width PKT_W, depth FIFO_DEPTH) with count, full and empty outputs.
- Tick generator and state machine stay in the top.

Test Plan:
- Reset: rst_n low mid-HOLD with 3 FIFO entries → all outputs 0 immediately; after release dat_ready = 1, no pulse for 200 cycles.
- Normal pacing: push 3 dat packets (…91, …93, …97) back-to-back → exactly three out_data_valid pulses, in order, 45 cycles apart.
- Priority: FIFO holds A, B; ctl packet C arrives during HOLD → issue order A, C, B.
- Overflow: push 5 dat packets with no drain (audio mode on, no tick yet) → dat_ready low after 4; 5th sets overflow = 1; FIFO content intact.
- Audio mode: audio_enable = 1 from IDLE → mode = 1 next cycle; tick every 114 cycles; 2 queued packets issue one each, on the cycle after successive ticks.
- Mode change deferral: drop audio_enable right after an audio issue → mode stays 1 until 44 cycles of HOLD elapse; tick counter is then held at 0 and normal issuing resumes.
